// File: rtl/resize_pipe_if.sv
// resize_pipe_if
//   Bundles the sample streams and statistics signals of resize_pipe.
//   Widths are carried as interface parameters. They must match the
//   parameters of the resize_pipe instance that the interface is connected to.
//
//   Signals:
//     in_dat/in_mode/in_valid -> input sample, per-sample mode and valid
//     in_ready                <- block can take an input sample this cycle
//     out_dat/out_sat         <- resized sample and its saturation flag
//     out_valid               <- output sample valid
//     out_ready               -> downstream takes the output sample
//     sat_cnt                 <- sticky count of saturated outputs taken
//     sat_cnt_clr             -> synchronous clear of sat_cnt
//
//   Modports:
//     slave  : the converter's view (resize_pipe)
//     master : the view of whatever feeds and drains the converter
interface resize_pipe_if #(
  parameter int WID_IN  = 18,
  parameter int WID_OUT = 24,
  parameter int CNT_WID = 16
) ();

  logic [WID_IN-1:0]  in_dat;
  logic [1:0]         in_mode;
  logic               in_valid;
  logic               in_ready;
  logic [WID_OUT-1:0] out_dat;
  logic               out_sat;
  logic               out_valid;
  logic               out_ready;
  logic [CNT_WID-1:0] sat_cnt;
  logic               sat_cnt_clr;

  modport slave (
    input  in_dat, in_mode, in_valid, out_ready, sat_cnt_clr,
    output in_ready, out_dat, out_sat, out_valid, sat_cnt
  );

  modport master (
    output in_dat, in_mode, in_valid, out_ready, sat_cnt_clr,
    input  in_ready, out_dat, out_sat, out_valid, sat_cnt
  );

endinterface

// File: rtl/resize_pipe.sv
// resize_pipe
//   Two-stage pipelined width converter for control-loop samples.
//   It converts WID_IN-bit samples to WID_OUT-bit samples after a fixed right
//   shift of SHIFT bits. Each sample carries its own mode:
//     00 signed saturate, 01 unsigned saturate, 10 signed wrap, 11 as 00.
//   Stage 1 registers the shifted sample and its mode. Stage 2 registers the
//   resized result. A valid/ready handshake gives one sample per cycle, and a
//   saturating counter records how many flagged outputs were taken.
//
//   Ports:
//     clk  : system clock
//     rst  : asynchronous reset, active high; drops all in-flight samples
//     bus  : resize_pipe_if slave modport (streams and sat statistics)
module resize_pipe #(
  parameter int WID_IN  = 18,
  parameter int WID_OUT = 24,
  parameter int SHIFT   = 0,
  parameter int CNT_WID = 16
) (
  input  logic          clk,
  input  logic          rst,
  resize_pipe_if.slave  bus
);

  // Width left after the shift. Both the arithmetic and the logical shift,
  // truncated to W bits, are just the top W bits of the input. The only
  // difference is how those bits are read (signed or unsigned). Dropping the
  // low bits is the floor (toward -inf) rounding.
  localparam int W = WID_IN - SHIFT;

  typedef logic [WID_OUT-1:0] out_t;

  logic               s1_valid;
  logic [W-1:0]       s1_v;
  logic [1:0]         s1_mode;
  logic               s1_en;
  logic               s2_en;
  logic               mode_uns;
  out_t               res_dat;
  logic               res_sat;
  logic               out_valid_q;
  out_t               out_dat_q;
  logic               out_sat_q;
  logic [CNT_WID-1:0] sat_cnt_q;

  // Stage 2 moves when it is empty or its sample is being taken. Stage 1
  // moves when it is empty or stage 2 moves. in_ready therefore depends
  // combinationally on out_ready.
  assign s2_en        = !out_valid_q || bus.out_ready;
  assign s1_en        = !s1_valid || s2_en;
  assign bus.in_ready = s1_en;

  assign bus.out_valid = out_valid_q;
  assign bus.out_dat   = out_dat_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.sat_cnt   = sat_cnt_q;

  // Stage 1 holds the already-shifted sample together with its mode, so that
  // a mode change applies exactly to the sample it came with.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_v     <= '0;
      s1_mode  <= 2'b00;
    end else if (s1_en) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_v    <= bus.in_dat[WID_IN-1:SHIFT];
        s1_mode <= bus.in_mode;
      end
    end
  end

  // Mode 11 is not decoded here, so it falls through to signed saturate.
  assign mode_uns = (s1_mode == 2'b01);

  generate
    if (WID_OUT >= W) begin : g_widen
      // Every shifted value fits the output. Signed modes sign-extend, the
      // unsigned mode zero-extends, and nothing is flagged.
      always_comb begin
        res_sat = 1'b0;
        if (mode_uns) begin
          res_dat = out_t'(s1_v);
        end else begin
          res_dat = out_t'($signed(s1_v));
        end
      end
    end else begin : g_narrow
      localparam out_t S_MAX = {1'b0, {(WID_OUT-1){1'b1}}};
      localparam out_t S_MIN = {1'b1, {(WID_OUT-1){1'b0}}};

      logic mode_wrap;
      logic sign_ok;
      logic uns_over;

      assign mode_wrap = (s1_mode == 2'b10);
      // A signed value fits when every bit above the output sign bit equals
      // that sign bit.
      assign sign_ok   = (&s1_v[W-1:WID_OUT-1]) | ~(|s1_v[W-1:WID_OUT-1]);
      // An unsigned value overflows when any bit above the output MSB is set.
      assign uns_over  = |s1_v[W-1:WID_OUT];

      // The default is plain truncation. Wrap mode keeps it and only raises
      // the flag. The saturating modes replace it with the nearest bound.
      always_comb begin
        res_dat = s1_v[WID_OUT-1:0];
        res_sat = 1'b0;
        if (mode_uns) begin
          if (uns_over) begin
            res_dat = '1;
            res_sat = 1'b1;
          end
        end else if (mode_wrap) begin
          res_sat = !sign_ok;
        end else if (!sign_ok) begin
          res_dat = s1_v[W-1] ? S_MIN : S_MAX;
          res_sat = 1'b1;
        end
      end
    end
  endgenerate

  // Stage 2 is the output register. While downstream stalls it holds its
  // sample, so out_dat/out_sat stay stable. The data registers load only
  // with a real sample, which keeps them at zero after reset until the
  // first sample arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_dat_q   <= '0;
      out_sat_q   <= 1'b0;
    end else if (s2_en) begin
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        out_dat_q <= res_dat;
        out_sat_q <= res_sat;
      end
    end
  end

  // The counter counts flagged samples only when downstream actually takes
  // them. It sticks at all-ones instead of wrapping. A clear wins over an
  // increment in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_cnt_q <= '0;
    end else if (bus.sat_cnt_clr) begin
      sat_cnt_q <= '0;
    end else if (out_valid_q && bus.out_ready && out_sat_q && !(&sat_cnt_q)) begin
      sat_cnt_q <= sat_cnt_q + 1'b1;
    end
  end

endmodule
